// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - MEM-stage and SRAM-controller signal bundle for cache_controller
// slave is the cache's view; master is the pipeline/SRAM side.
interface cache_controller_if;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_read_enable;
  logic        sram_write_enable;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  modport slave (
    input  read_enable, write_enable, address, write_data, sram_read_data, sram_ready,
    output read_data, ready, sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

  modport master (
    output read_enable, write_enable, address, write_data, sram_read_data, sram_ready,
    input  read_data, ready, sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative write-through read-allocate data cache
// Read hits complete combinationally; misses and all writes stall the pipeline on the SRAM controller.
module cache_controller #(
  parameter int SET_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t state, next_state;

  logic [SETS-1:0]  valid0, valid1, lru;
  logic [TAG_W-1:0] tag0  [SETS];
  logic [TAG_W-1:0] tag1  [SETS];
  logic [31:0]      data0 [SETS];
  logic [31:0]      data1 [SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit0, hit1, hit_way, victim;

  logic        ready, rd_en_q, wr_en_q;
  logic [31:0] read_data;
  logic        fill_en, fill_way, upd_en, upd_way, lru_en, lru_val;

  assign idx     = bus.address[SET_BITS+1:2];
  assign tag     = bus.address[31:SET_BITS+2];
  assign hit0    = valid0[idx] && (tag0[idx] == tag);
  assign hit1    = valid1[idx] && (tag1[idx] == tag);
  assign hit_way = !hit0;
  assign victim  = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    read_data  = '0;
    fill_en    = 1'b0;
    fill_way   = 1'b0;
    upd_en     = 1'b0;
    upd_way    = 1'b0;
    lru_en     = 1'b0;
    lru_val    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read_enable) begin
          if (hit0 || hit1) begin
            ready     = 1'b1;
            read_data = hit0 ? data0[idx] : data1[idx];
            lru_en    = 1'b1;
            lru_val   = ~hit_way;
          end else begin
            next_state = RD_REQ;
          end
        end else if (bus.write_enable) begin
          next_state = WR_REQ;
        end else begin
          ready = 1'b1;
        end
      end
      RD_REQ:  next_state = RD_WAIT;
      RD_WAIT: begin
        if (bus.sram_ready) begin
          fill_en    = 1'b1;
          fill_way   = victim;
          lru_en     = 1'b1;
          lru_val    = ~victim;
          read_data  = bus.sram_read_data;
          ready      = 1'b1;
          next_state = IDLE;
        end
      end
      WR_REQ:  next_state = WR_WAIT;
      WR_WAIT: begin
        if (bus.sram_ready) begin
          // write-through: refresh a resident copy, never allocate on a write miss
          if (hit0 || hit1) begin
            upd_en  = 1'b1;
            upd_way = hit_way;
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end
          ready      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (!rst) begin
      ready      = 1'b1;
      read_data  = '0;
      fill_en    = 1'b0;
      upd_en     = 1'b0;
      lru_en     = 1'b0;
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      valid0  <= '0;
      valid1  <= '0;
      lru     <= '0;
    end else begin
      state   <= next_state;
      rd_en_q <= (next_state == RD_REQ);
      wr_en_q <= (next_state == WR_REQ);
      if (fill_en) begin
        if (fill_way) valid1[idx] <= 1'b1;
        else          valid0[idx] <= 1'b1;
      end
      if (lru_en) lru[idx] <= lru_val;
    end
  end

  // Tag/data arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (fill_way) begin
        tag1[idx]  <= tag;
        data1[idx] <= bus.sram_read_data;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= bus.sram_read_data;
      end
    end
    if (upd_en) begin
      if (upd_way) data1[idx] <= bus.write_data;
      else         data0[idx] <= bus.write_data;
    end
  end

  assign bus.ready             = ready;
  assign bus.read_data         = read_data;
  assign bus.sram_read_enable  = rd_en_q;
  assign bus.sram_write_enable = wr_en_q;
  assign bus.sram_address      = bus.address;
  assign bus.sram_write_data   = bus.write_data;
endmodule
